mem_ctrl: RTL and testbench

- Arbitrates the single byte-wide unified RAM between instruction fetch (IF) and the load/store stage (MEM).
- Serialises 1/2/4-byte accesses into byte cycles and reassembles them little-endian.
- Produces per-requester stall requests that feed the stall bus, which freezes the IF/ID and later pipeline registers.
- Honours the EX-stage discard so a stale fetch is dropped on a branch mispredict.

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the unified-RAM controller: FSM states, access lengths
// and the default RAM address width.
package mem_ctrl_pkg;

  localparam int RAM_ADDR_W_DEF = 17;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_IF_RD  = 2'b01;
  localparam logic [1:0] ST_MEM_RD = 2'b10;
  localparam logic [1:0] ST_MEM_WR = 2'b11;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic [2:0] IF_BYTES = 3'd4;

  // Length code 11 is treated as a word access.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide unified RAM between instruction fetch and load/store,
// serialising multi-byte accesses into byte cycles assembled little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  discard,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  if_stall_req,
  output logic                  mem_stall_req,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  ram_wr
);

  logic [1:0]            state;
  logic [2:0]            cnt;
  logic [2:0]            n;
  logic [RAM_ADDR_W-1:0] base;
  logic [31:0]           wbuf;
  logic [31:0]           rbuf;
  logic [31:0]           rbuf_nxt;
  logic [7:0]            wr_byte;
  logic                  unused_addr_hi;

  // Requester addresses beyond the RAM are simply truncated.
  assign unused_addr_hi = ^{if_addr[31:RAM_ADDR_W], mem_addr[31:RAM_ADDR_W]};

  assign if_stall_req  = if_req & ~if_done;
  assign mem_stall_req = mem_req & ~mem_done;
  assign ram_addr      = base + RAM_ADDR_W'(cnt);
  assign ram_wr        = (state == ST_MEM_WR) && (cnt < n);
  assign ram_dout      = wr_byte;

  // RAM data lags its address by one cycle, so the byte landing now is cnt-1.
  always_comb begin
    rbuf_nxt = rbuf;
    case (cnt)
      3'd1:    rbuf_nxt[7:0]   = ram_din;
      3'd2:    rbuf_nxt[15:8]  = ram_din;
      3'd3:    rbuf_nxt[23:16] = ram_din;
      3'd4:    rbuf_nxt[31:24] = ram_din;
      default: rbuf_nxt = rbuf;
    endcase
  end

  always_comb begin
    wr_byte = wbuf[7:0];
    case (cnt[1:0])
      2'd1:    wr_byte = wbuf[15:8];
      2'd2:    wr_byte = wbuf[23:16];
      2'd3:    wr_byte = wbuf[31:24];
      default: wr_byte = wbuf[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      n         <= 3'd0;
      base      <= '0;
      wbuf      <= 32'd0;
      rbuf      <= 32'd0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A requester still in its done cycle must not be re-accepted.
          if (!if_done && !mem_done) begin
            if (mem_req) begin
              state <= mem_we ? ST_MEM_WR : ST_MEM_RD;
              base  <= mem_addr[RAM_ADDR_W-1:0];
              n     <= len_to_bytes(mem_len);
              wbuf  <= mem_wdata;
              rbuf  <= 32'd0;
              cnt   <= 3'd0;
            end else if (if_req && !discard) begin
              state <= ST_IF_RD;
              base  <= if_addr[RAM_ADDR_W-1:0];
              n     <= IF_BYTES;
              rbuf  <= 32'd0;
              cnt   <= 3'd0;
            end
          end
        end
        ST_IF_RD, ST_MEM_RD: begin
          if (state == ST_IF_RD && discard) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
          end else begin
            rbuf <= rbuf_nxt;
            if (cnt == n) begin
              state <= ST_IDLE;
              cnt   <= 3'd0;
              if (state == ST_IF_RD) begin
                if_data <= rbuf_nxt;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= rbuf_nxt;
                mem_done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: begin
          if (cnt == n - 3'd1) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            mem_done <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-array RAM, directed scenarios plus randomized
// concurrent IF/MEM traffic, scored against a shadow-memory reference model.
module tb_mem_ctrl;

  localparam int AW   = 17;
  localparam int RSZ  = 1 << AW;
  localparam logic [31:0] MASK = 32'h0001_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, discard, mem_req, mem_we;
  logic [31:0]   if_addr, mem_addr, mem_wdata;
  logic [1:0]    mem_len;
  logic [31:0]   if_data, mem_rdata;
  logic          if_done, mem_done, if_stall_req, mem_stall_req, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout, ram_din;

  logic [7:0]  ram [0:RSZ-1];
  logic [7:0]  mdl [0:RSZ-1];
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] last_load;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;
  int if_done_cyc, mem_done_cyc;

  mem_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .discard(discard),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // Synchronous-read byte RAM: data appears one cycle after its address.
  always @(posedge clk) begin
    cyc++;
    ram_din <= ram[ram_addr];
    if (ram_wr) begin
      ram[ram_addr] <= ram_dout;
      wr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int len_n(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int nb);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < nb; k++) r[8*k +: 8] = mdl[int'((a + 32'(k)) & MASK)];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input int nb, input logic [31:0] d);
    for (int k = 0; k < nb; k++) mdl[int'((a + 32'(k)) & MASK)] = d[8*k +: 8];
  endtask

  // Monitor: pops expectations whenever the DUT signals completion.
  always @(negedge clk) begin
    if (!rst) begin
      check("if_stall_req", {31'd0, if_stall_req}, {31'd0, if_req & ~if_done});
      check("mem_stall_req", {31'd0, mem_stall_req}, {31'd0, mem_req & ~mem_done});
      if (if_done) begin
        if (if_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL if_done_unexpected: got if_done=1 required 0");
        end else check("if_data", if_data, if_q.pop_front());
      end
      if (mem_done) begin
        if (mem_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_done_unexpected: got mem_done=1 required 0");
        end else check("mem_rdata", mem_rdata, mem_q.pop_front());
      end
    end
  end

  task automatic if_op(input logic [31:0] addr, input int exp_lat, output logic [31:0] data);
    int start, t;
    if_q.push_back(model_read(addr, 4));
    if_addr = addr;
    if_req  = 1'b1;
    start   = cyc;
    t = 0;
    do begin @(negedge clk); t++; end while (!if_done && t < 60);
    check("if_done_seen", {31'd0, if_done}, 32'd1);
    if (exp_lat >= 0) check("if_latency", 32'(cyc - start), 32'(exp_lat));
    data = if_data;
    if_done_cyc = cyc;
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic mem_op(input logic we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_lat);
    int start, t;
    if (we) begin
      model_write(addr, len_n(len), wd);
      mem_q.push_back(last_load);
    end else begin
      last_load = model_read(addr, len_n(len));
      mem_q.push_back(last_load);
    end
    mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
    mem_req = 1'b1;
    start   = cyc;
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_done && t < 60);
    check("mem_done_seen", {31'd0, mem_done}, 32'd1);
    if (exp_lat >= 0) check("mem_latency", 32'(cyc - start), 32'(exp_lat));
    mem_done_cyc = cyc;
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[int'(a & MASK)] = b;
    mdl[int'(a & MASK)] = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d1, ia, ma, wd;
    logic        we;
    logic [1:0]  ln;
    int          w0, dn, sel, mism;

    for (int i = 0; i < RSZ; i++) begin
      ram[i] = 8'($urandom);
      mdl[i] = ram[i];
    end
    last_load = 32'd0;
    rst = 1'b1; if_req = 1'b0; discard = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'b00; if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain fetch
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
    w0 = wr_cnt;
    if_op(32'h100, 6, d1);
    check("fetch_word", d1, 32'h00A0_0513);
    check("fetch_no_wr", 32'(wr_cnt - w0), 32'd0);

    // Contention: MEM served first, IF after
    poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
    fork
      mem_op(1'b0, 2'b10, 32'h200, 32'd0, 6);
      if_op(32'h100, 13, d1);
    join
    check("contention_load", mem_rdata, 32'hDEAD_BEEF);
    check("contention_order", {31'd0, mem_done_cyc < if_done_cyc}, 32'd1);

    // Store half wrapping past the top of RAM
    w0 = wr_cnt;
    mem_op(1'b1, 2'b01, 32'h0001_FFFF, 32'h1234_5678, 3);
    check("store_wr_cycles", 32'(wr_cnt - w0), 32'd2);
    check("store_top_byte", {24'd0, ram[RSZ-1]}, 32'h78);
    check("store_wrap_byte", {24'd0, ram[0]}, 32'h56);
    check("store_keeps_rdata", mem_rdata, 32'hDEAD_BEEF);

    // Byte load, zero-extended
    poke(32'h300, 8'h80);
    mem_op(1'b0, 2'b00, 32'h300, 32'd0, 3);
    check("byte_load", mem_rdata, 32'h0000_0080);

    // Discard during the second byte of a fetch
    if_addr = 32'h400; if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    discard = 1'b1; if_req = 1'b0;
    @(negedge clk);
    discard = 1'b0;
    dn = 0;
    repeat (8) begin @(negedge clk); dn += int'(if_done); end
    check("discard_no_done", 32'(dn), 32'd0);
    if_op(32'h400, 6, d1);
    check("refetch_word", d1, model_read(32'h400, 4));

    // Async reset in the middle of a word store
    wd = $urandom;
    mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h500; mem_wdata = wd; mem_req = 1'b1;
    repeat (3) @(negedge clk);
    check("wr_before_rst", {31'd0, ram_wr}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_async_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_async_mem_rdata", mem_rdata, 32'd0);
    check("rst_async_if_data", if_data, 32'd0);
    mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_load = 32'd0;
    model_write(32'h500, 2, wd);
    check("partial_store", {ram[32'h503], ram[32'h502], ram[32'h501], ram[32'h500]},
          model_read(32'h500, 4));
    @(negedge clk);

    // Randomized concurrent traffic: fetches low half, load/store high half
    for (int i = 0; i < 40; i++) begin
      ia  = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 32'hFFF0));
      ma  = ($urandom & 32'hFFFE_0000) | (32'h1_0000 + 32'($urandom_range(0, 32'hFFF0)));
      wd  = $urandom;
      we  = 1'($urandom);
      ln  = 2'($urandom);
      sel = int'($urandom_range(0, 2));
      fork
        if (sel != 1) if_op(ia, -1, d1);
        if (sel != 0) mem_op(we, ln, ma, wd, -1);
      join
    end

    mism = 0;
    for (int i = 0; i < RSZ; i++) if (ram[i] !== mdl[i]) mism++;
    check("ram_image", 32'(mism), 32'd0);
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
